// File: rtl/parking_occupancy_controller.sv
// rtl/parking_occupancy_controller.sv - multi-gate saturating parking occupancy counter
// Rising sensor edges from all gates are netted each cycle and clipped into 0..CAP.
module parking_occupancy_controller #(
  parameter int GATES  = 2,
  parameter int CAP    = 15,
  parameter int CW     = 4,
  parameter int ALMOST = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*GATES-1:0] inc_dec,
  input  logic               clear,
  output logic [CW-1:0]      count,
  output logic [CW-1:0]      free,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               err_overflow,
  output logic               err_underflow,
  output logic [GATES-1:0]   gate_open
);

  localparam int EW = $clog2(GATES + 1);
  localparam int SW = CW + EW + 1;

  localparam logic signed [SW-1:0] ONE      = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [SW-1:0] CAP_S    = SW'(CAP);
  localparam logic        [CW-1:0] CAP_C    = CW'(CAP);
  localparam logic        [CW-1:0] ALMOST_C = CW'(ALMOST);

  logic [2*GATES-1:0]    prev;
  logic [2*GATES-1:0]    rise;
  logic signed [SW-1:0]  e_cnt;
  logic signed [SW-1:0]  x_cnt;
  logic signed [SW-1:0]  n_sum;
  logic                  ovf;
  logic                  unf;
  logic [CW-1:0]         next_count;

  assign rise = inc_dec & ~prev;

  // A gate whose entry and exit fire together is a sensor fault: both are dropped.
  always_comb begin
    e_cnt = '0;
    x_cnt = '0;
    for (int g = 0; g < GATES; g++) begin
      if (rise[2*g+1] && !rise[2*g]) e_cnt = e_cnt + ONE;
      if (rise[2*g] && !rise[2*g+1]) x_cnt = x_cnt + ONE;
    end
    n_sum      = $signed({{(SW-CW){1'b0}}, count}) + e_cnt - x_cnt;
    ovf        = n_sum > CAP_S;
    unf        = n_sum[SW-1];
    next_count = n_sum[CW-1:0];
    if (ovf) next_count = CAP_C;
    else if (unf) next_count = '0;
  end

  // prev resets high so a sensor held through reset release does not count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev          <= '1;
      count         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      prev <= inc_dec;
      if (clear) begin
        count         <= '0;
        err_overflow  <= 1'b0;
        err_underflow <= 1'b0;
      end else begin
        count <= next_count;
        if (ovf) err_overflow <= 1'b1;
        if (unf) err_underflow <= 1'b1;
      end
    end
  end

  assign free        = CAP_C - count;
  assign full        = (count == CAP_C);
  assign empty       = (count == '0);
  assign almost_full = (free <= ALMOST_C);
  assign gate_open   = {GATES{~full}};

endmodule
